// File: rtl/countgen_pkg.sv
// Shared widths, minimum sub-period length and generator states for the countgen pulse regenerator.
// Latency: n/a. Backpressure: n/a.
package countgen_pkg;

    localparam int PERIOD_W_DEF = 32;
    localparam int MULT_W_DEF   = 8;
    localparam int MIN_SUB_DEF  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_t;

endpackage

// File: rtl/countgen_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses DW+1 cycles after start is taken.
// Backpressure: start is ignored while busy; results hold until the next start.
module countgen_divider #(
    parameter int DW = 32,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] quo;
    logic [VW-1:0] rem;
    logic [VW-1:0] dsr;
    logic [VW:0]   rem_sh;
    logic [VW:0]   diff;

    // Partial remainder always stays below the divisor, so VW+1 bits suffice for the trial subtract.
    always_comb begin
        rem_sh = {rem, quo[DW-1]};
        diff   = rem_sh - {1'b0, dsr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dsr  <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy <= 1'b1;
                cnt  <= CW'(DW);
                quo  <= dividend;
                rem  <= '0;
                dsr  <= divisor;
            end else if (busy) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                    if (!diff[VW]) begin
                        rem <= diff[VW-1:0];
                        quo <= {quo[DW-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[VW-1:0];
                        quo <= {quo[DW-2:0], 1'b0};
                    end
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient    = quo;
    assign remainder   = rem;
    assign div_by_zero = (dsr == '0);

endmodule

// File: rtl/countgen_pulsegen.sv
// Frequency multiplier: emits mult evenly spaced pulses per measured period, in whole batches.
// Latency: first pulse ~PERIOD_W+4 cycles after enable. Backpressure: none; period/mult apply at batch boundaries.
import countgen_pkg::*;

module countgen_pulsegen #(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int MULT_W   = MULT_W_DEF,
    parameter int MIN_SUB  = MIN_SUB_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] period,
    input  logic [MULT_W-1:0]   mult,
    input  logic                enable,
    output logic                out,
    output logic                busy,
    output logic [PERIOD_W-1:0] sub_len,
    output logic                err
);

    logic                div_start;
    logic                div_busy;
    logic                div_done;
    logic                div_dbz;
    logic [PERIOD_W-1:0] div_q;
    logic [MULT_W-1:0]   div_r;
    logic                div_reject;
    logic                div_accept;

    logic                cap_pzero;
    logic [MULT_W-1:0]   cap_mult;

    logic                nxt_valid;
    logic [PERIOD_W-1:0] nxt_q;
    logic [MULT_W-1:0]   nxt_r;
    logic [MULT_W-1:0]   nxt_mult;

    gen_state_t          state;
    gen_state_t          state_nx;
    logic                load_batch;
    logic                batch_end;
    logic [PERIOD_W-1:0] ld_q;
    logic [MULT_W-1:0]   ld_r;
    logic [MULT_W-1:0]   ld_mult;

    logic [PERIOD_W-1:0] w_q;
    logic [MULT_W-1:0]   w_r;
    logic [MULT_W-1:0]   w_mult;
    logic [MULT_W-1:0]   k;
    logic [MULT_W-1:0]   k_inc;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cur_len;
    logic [PERIOD_W-1:0] hi_thr;

    assign div_start = enable && !div_busy;

    countgen_divider #(
        .DW (PERIOD_W),
        .VW (MULT_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .dividend    (period),
        .divisor     (mult),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_by_zero (div_dbz)
    );

    // period==0 would also give q<MIN_SUB, but is flagged explicitly in case MIN_SUB is set to 0.
    assign div_reject = div_dbz || cap_pzero || (div_q < PERIOD_W'(MIN_SUB));
    assign div_accept = div_done && !div_reject && enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_pzero <= 1'b0;
            cap_mult  <= '0;
            nxt_valid <= 1'b0;
            nxt_q     <= '0;
            nxt_r     <= '0;
            nxt_mult  <= '0;
            err       <= 1'b0;
        end else begin
            err <= div_done && div_reject;
            if (div_start) begin
                cap_pzero <= (period == '0);
                cap_mult  <= mult;
            end
            if (!enable) begin
                nxt_valid <= 1'b0;
            end else if (div_accept) begin
                nxt_valid <= 1'b1;
                nxt_q     <= div_q;
                nxt_r     <= div_r;
                nxt_mult  <= cap_mult;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_batch = 1'b0;
        // A result completing on this cycle bypasses the next register.
        ld_q       = div_accept ? div_q    : nxt_q;
        ld_r       = div_accept ? div_r    : nxt_r;
        ld_mult    = div_accept ? cap_mult : nxt_mult;
        batch_end  = (cnt == PERIOD_W'(1)) && (k == w_mult - MULT_W'(1));
        case (state)
            IDLE: begin
                if (enable && nxt_valid) begin
                    state_nx   = RUN;
                    load_batch = 1'b1;
                end
            end
            RUN: begin
                if (batch_end) begin
                    if (enable && (div_accept || nxt_valid)) begin
                        load_batch = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sub-periods k<r carry one extra cycle so the batch spans exactly q*mult+r cycles.
    always_comb begin
        k_inc   = k + MULT_W'(1);
        cur_len = w_q + {{(PERIOD_W-1){1'b0}}, (k < w_r)};
        hi_thr  = cur_len - (cur_len >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q     <= '0;
            w_r     <= '0;
            w_mult  <= '0;
            k       <= '0;
            cnt     <= '0;
            sub_len <= '0;
        end else if (load_batch) begin
            w_q     <= ld_q;
            w_r     <= ld_r;
            w_mult  <= ld_mult;
            k       <= '0;
            cnt     <= ld_q + {{(PERIOD_W-1){1'b0}}, (ld_r != '0)};
            sub_len <= ld_q;
        end else if (state == RUN) begin
            if (cnt == PERIOD_W'(1)) begin
                if (batch_end) begin
                    sub_len <= '0;
                end else begin
                    k   <= k_inc;
                    cnt <= w_q + {{(PERIOD_W-1){1'b0}}, (k_inc < w_r)};
                end
            end else begin
                cnt <= cnt - PERIOD_W'(1);
            end
        end
    end

    // cnt runs len..1; the high phase is the first floor(len/2) of those cycles.
    assign out  = (state == RUN) && (cnt > hi_thr);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_countgen_pulsegen.sv
// Scoreboard bench for countgen_pulsegen: expected sub-period records are queued with the stimulus
// and matched against records rebuilt from the out/busy/sub_len waveforms.
module tb_countgen_pulsegen;

    localparam int PW = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [PW-1:0] period = '0;
    logic [MW-1:0] mult = '0;
    logic          out;
    logic          busy;
    logic [PW-1:0] sub_len;
    logic          err;

    typedef struct {
        int hi;
        int len;
        int sl;
    } rec_t;

    rec_t obs[$];
    rec_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int   hi_c = 0;
    int   lo_c = 0;
    int   cur_sl = 0;
    int   err_cnt = 0;
    int   err_hi = 0;
    int   busy_cyc = 0;
    int   out_cyc = 0;
    logic prev_err = 1'b0;

    always #5 clk = ~clk;

    countgen_pulsegen dut (
        .clk     (clk),
        .rst     (rst),
        .period  (period),
        .mult    (mult),
        .enable  (enable),
        .out     (out),
        .busy    (busy),
        .sub_len (sub_len),
        .err     (err)
    );

    // Rebuild one record per sub-period: a high run followed by a low run.
    always @(negedge clk) begin
        if (rst) begin
            obs.delete();
            hi_c     <= 0;
            lo_c     <= 0;
            err_cnt  <= 0;
            err_hi   <= 0;
            busy_cyc <= 0;
            out_cyc  <= 0;
            prev_err <= 1'b0;
        end else begin
            prev_err <= err;
            if (err) begin
                err_hi <= err_hi + 1;
                if (!prev_err) err_cnt <= err_cnt + 1;
            end
            if (busy) busy_cyc <= busy_cyc + 1;
            if (out) begin
                out_cyc <= out_cyc + 1;
                if (lo_c > 0) begin
                    obs.push_back(rec_t'{hi: hi_c, len: hi_c + lo_c, sl: cur_sl});
                    hi_c   <= 1;
                    lo_c   <= 0;
                    cur_sl <= int'(sub_len);
                end else begin
                    if (hi_c == 0) cur_sl <= int'(sub_len);
                    hi_c <= hi_c + 1;
                end
            end else if (busy && hi_c > 0) begin
                lo_c <= lo_c + 1;
            end else if (!busy && hi_c > 0) begin
                obs.push_back(rec_t'{hi: hi_c, len: hi_c + lo_c, sl: cur_sl});
                hi_c <= 0;
                lo_c <= 0;
            end
        end
    end

    task automatic apply_reset();
        rst    = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int t = 0;
        while (obs.size() < n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        ok = (obs.size() >= n);
    endtask

    task automatic wait_busy(input int budget, output int lat);
        lat = 0;
        while (busy !== 1'b1 && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out !== 1'b0)  begin errors++; $display("FAIL reset_out: got %b want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (sub_len !== '0) begin errors++; $display("FAIL reset_sub_len: got %0d want 0", sub_len); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_basic();
        bit ok;
        rec_t r, e;
        apply_reset();
        period = 1000; mult = 4; enable = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(rec_t'{hi: 125, len: 250, sl: 250});
        wait_obs(8, 6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d records want 8", obs.size()); end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            r = obs.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.hi !== e.hi || r.len !== e.len || r.sl !== e.sl) begin
                errors++;
                $display("FAIL basic_rec: got hi=%0d len=%0d sl=%0d want hi=%0d len=%0d sl=%0d", r.hi, r.len, r.sl, e.hi, e.len, e.sl);
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL basic_err: got %0d pulses want 0", err_cnt); end
    endtask

    task automatic test_remainder();
        bit ok;
        rec_t r, e;
        apply_reset();
        period = 1003; mult = 4; enable = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back(rec_t'{hi: 125, len: 251, sl: 250});
            exp_q.push_back(rec_t'{hi: 125, len: 250, sl: 250});
        end
        wait_obs(8, 6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rem_timeout: got %0d records want 8", obs.size()); end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            r = obs.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.hi !== e.hi || r.len !== e.len || r.sl !== e.sl) begin
                errors++;
                $display("FAIL rem_rec: got hi=%0d len=%0d sl=%0d want hi=%0d len=%0d sl=%0d", r.hi, r.len, r.sl, e.hi, e.len, e.sl);
            end
        end
    endtask

    task automatic test_reject();
        int exp_div;
        logic [MW-1:0] mults [2];
        mults[0] = 8'd4;
        mults[1] = 8'd0;
        exp_div = 400 / (PW + 2);
        for (int m = 0; m < 2; m++) begin
            apply_reset();
            period = 5; mult = mults[m]; enable = 1'b1;
            repeat (400) @(posedge clk);
            #1;
            checks++;
            if (err_cnt < exp_div - 1 || err_cnt > exp_div + 1) begin
                errors++; $display("FAIL reject_err_count m=%0d: got %0d want %0d+-1", mults[m], err_cnt, exp_div);
            end
            checks++; if (err_hi !== err_cnt) begin errors++; $display("FAIL reject_err_width m=%0d: got %0d high cycles want %0d", mults[m], err_hi, err_cnt); end
            checks++; if (busy_cyc !== 0) begin errors++; $display("FAIL reject_busy m=%0d: got %0d busy cycles want 0", mults[m], busy_cyc); end
            checks++; if (out_cyc !== 0) begin errors++; $display("FAIL reject_out m=%0d: got %0d out cycles want 0", mults[m], out_cyc); end
        end
        enable = 1'b0;
    endtask

    task automatic test_period_change();
        bit ok;
        rec_t r, e;
        apply_reset();
        period = 1000; mult = 4; enable = 1'b1;
        exp_q.push_back(rec_t'{hi: 125, len: 250, sl: 250});
        wait_obs(1, 2000, ok);
        // Now inside sub-period 1 of the first batch.
        period = 2000;
        for (int i = 0; i < 3; i++) exp_q.push_back(rec_t'{hi: 125, len: 250, sl: 250});
        for (int i = 0; i < 4; i++) exp_q.push_back(rec_t'{hi: 250, len: 500, sl: 500});
        wait_obs(8, 6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL change_timeout: got %0d records want 8", obs.size()); end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            r = obs.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.hi !== e.hi || r.len !== e.len || r.sl !== e.sl) begin
                errors++;
                $display("FAIL change_rec: got hi=%0d len=%0d sl=%0d want hi=%0d len=%0d sl=%0d", r.hi, r.len, r.sl, e.hi, e.len, e.sl);
            end
        end
    endtask

    task automatic test_disable();
        bit ok;
        int lat;
        rec_t r, e;
        apply_reset();
        period = 1000; mult = 4; enable = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(rec_t'{hi: 125, len: 250, sl: 250});
        wait_obs(2, 2000, ok);
        enable = 1'b0;
        wait_obs(4, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dis_timeout: got %0d records want 4", obs.size()); end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            r = obs.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.hi !== e.hi || r.len !== e.len || r.sl !== e.sl) begin
                errors++;
                $display("FAIL dis_rec: got hi=%0d len=%0d sl=%0d want hi=%0d len=%0d sl=%0d", r.hi, r.len, r.sl, e.hi, e.len, e.sl);
            end
        end
        repeat (300) @(posedge clk);
        #1;
        checks++; if (obs.size() !== 0) begin errors++; $display("FAIL dis_extra: got %0d extra records want 0", obs.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b want 0", busy); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL dis_out: got %b want 0", out); end
        enable = 1'b1;
        wait_busy(200, lat);
        checks++;
        if (busy !== 1'b1 || lat < PW + 1) begin
            errors++; $display("FAIL reenable_latency: got %0d cycles busy=%b want >=%0d and busy=1", lat, busy, PW + 1);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int lat;
        rec_t r;
        apply_reset();
        period = 1000; mult = 4; enable = 1'b1;
        wait_obs(2, 2000, ok);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (out !== 1'b0)  begin errors++; $display("FAIL arst_out: got %b want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (sub_len !== '0) begin errors++; $display("FAIL arst_sub_len: got %0d want 0", sub_len); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL arst_err: got %b want 0", err); end
        @(posedge clk);
        #1 rst = 1'b0;
        wait_busy(200, lat);
        checks++;
        if (busy !== 1'b1 || lat < PW + 1) begin
            errors++; $display("FAIL arst_restart: got %0d cycles busy=%b want >=%0d and busy=1", lat, busy, PW + 1);
        end
        wait_obs(1, 2000, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL arst_rec_timeout: got 0 records want 1");
        end else begin
            r = obs.pop_front();
            if (r.hi !== 125 || r.len !== 250 || r.sl !== 250) begin
                errors++; $display("FAIL arst_rec: got hi=%0d len=%0d sl=%0d want hi=125 len=250 sl=250", r.hi, r.len, r.sl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_remainder();
        test_reject();
        test_period_change();
        test_disable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/countgen_pulsegen.md
Name: countgen_pulsegen

Overview:
- Downstream consumer of the period measurement stage. Takes the measured input period in clock cycles and regenerates a pulse train with `mult` evenly spaced pulses per measured period, i.e. a frequency multiplier.
- A background divider computes sub-period length from the latest period. The output generator runs whole batches of `mult` pulses, so period changes never glitch the output.

Parameters:
- PERIOD_W, 32, width of period input and internal length counters
- MULT_W, 8, width of multiplier input
- MIN_SUB, 2, smallest legal sub-period length in cycles

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- period  in  PERIOD_W  latest measured period (cycles); may change on any cycle
- mult  in  MULT_W  pulses per period; sampled with period
- enable  in  1  run request
- out  out  1  regenerated pulse train
- busy  out  1  high while a batch is being emitted
- sub_len  out  PERIOD_W  base sub-period length (quotient) of the batch in progress
- err  out  1  one-cycle pulse: division result rejected

Behaviour:
- Reset: all state cleared immediately, no clock edge needed. out=0, busy=0, sub_len=0, err=0, divider idle, no valid result held.
- Divider (background, always active while enable=1):
  - When idle, captures period/mult and starts.
  - Computes q=period/mult, r=period%mult by restoring division, one bit per cycle.
  - done asserts PERIOD_W+1 cycles after capture, then re-captures on the next cycle.
  - Result rejected if mult==0, period==0 or q<MIN_SUB. On rejection: err pulses 1 cycle, the held result is left unchanged.
  - Otherwise (q,r) is written to the "next" register, and next_valid is set.
- Generator FSM, states IDLE, RUN:
  - IDLE: out=0, busy=0. Enter RUN on the cycle after enable=1 && next_valid.
  - RUN entry / batch start:
    - Load q,r from next into working regs; sub_len<=q.
    - Sub-period index k counts 0..mult-1.
    - Sub-period k lasts q+1 cycles if k<r, else q cycles, so the batch totals exactly the captured period.
    - out=1 for the first floor(len/2) cycles of each sub-period, 0 for the rest.
  - End of last sub-period: if enable=1, start the next batch with zero gap, using the most recent valid next result. Otherwise go to IDLE.
- enable deassert mid-batch: the current batch completes unchanged, then IDLE. The divider stops capturing new values, but a division already in flight completes.
- period/mult changes mid-batch never affect the current batch. They apply at the first batch boundary after the divider has produced a result from them.
- Simultaneous divider done and batch boundary: the new result is used (bypass) for the batch starting that cycle.
- next_valid clears on enable deassert. The first batch after re-enable waits for a fresh division.
- busy=1 for every RUN cycle. err is independent of FSM state.
- Arithmetic:
  - Sub-period counter is PERIOD_W bits and counts down to 1.
  - The q+1 case cannot overflow, because r>0 implies q<2^PERIOD_W-1.

Decomposition:
- Package countgen_pkg: PERIOD_W/MULT_W defaults, MIN_SUB, generator state enum {IDLE, RUN}.
- Sub-module countgen_divider:
  - unsigned restoring divider
  - ports: clk, rst, start, dividend, divisor → busy, done, quotient, remainder, div_by_zero
- Top level holds result qualification, next register and the generator FSM.

Test Plan:
- period=1000, mult=4, enable=1 → err=0. After the first division, 4 sub-periods of 250 cycles, out high 125 / low 125 each. sub_len=250, busy=1, batches back-to-back.
- period=1003, mult=4 → sub-periods 251, 251, 251, 250 cycles (highs 125, 125, 125, 125). Batch total = 1003 cycles.
- period=5, mult=4 (q=1) and separately mult=0 → err pulses once per division. out=0 and busy=0 throughout, because no valid result exists.
- Running at 1000/4, switch period to 2000 mid-batch → current batch stays at 250. Later batches use 500 once the divider has completed with 2000, with no gap or runt pulse at the boundary.
- enable=0 during sub-period 2 of a 1000/4 batch → sub-periods 2 and 3 complete normally, then out=0 and busy=0. Re-enable → the first pulse appears only after a fresh division (≥PERIOD_W+1 cycles).
- Assert rst asynchronously mid-RUN, between clock edges → out, busy, sub_len and err go to 0 immediately. After release, the block stays IDLE until enable and a new division completes.
